ir_load_sequencer: RTL

- Sequences the IR/DRAM datapath. Generates the loadIR, mbXfer and loadDRAM strobes in the required order with a programmable settle gap, then reports that the dispatch fields (DRAM A/B/J) are valid to the microcode sequencer.
- Arbitrates the IR board between normal instruction loads and diagnostic EBUS functions: load function 06X and read function 13X.
- Sits between the CRAM/SPEC control logic, the cache/MB data-ready path, the diagnostic EBUS decoder and the IR datapath.

---
 rtl/ir_ctl_pkg.sv | 25 ++
 rtl/ir_seq_counter.sv | 26 ++
 rtl/ir_load_sequencer.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/ir_ctl_pkg.sv
// Shared definitions for the IR/DRAM load sequencer: state encoding and
// diagnostic function code groups.
package ir_ctl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_CACHE,
        ST_LOAD_IR,
        ST_SETTLE,
        ST_LOAD_DRAM,
        ST_VALID,
        ST_DIAG_LOAD,
        ST_DIAG_READ
    } ir_state_t;

    localparam logic [6:0] DIAG_LOAD_06X_BASE = 7'o060;
    localparam logic [6:0] DIAG_READ_13X_BASE = 7'o130;
    localparam logic [6:0] DIAG_GROUP_MASK    = 7'o170;

    // True when code falls in the eight-function group starting at base.
    function automatic logic diag_in_group(input logic [6:0] code, input logic [6:0] base);
        return (code & DIAG_GROUP_MASK) == base;
    endfunction

endpackage

// File: rtl/ir_seq_counter.sv
// Loadable 8-bit down-counter with zero flag, shared by the timed states of
// the IR load sequencer.
module ir_seq_counter (
    input  logic       clk,
    input  logic       resetN,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       dec,
    output logic       zero
);

    logic [7:0] count;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 8'd1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/ir_load_sequencer.sv
// Orders loadIR / mbXfer / loadDRAM with a settle gap and arbitrates the IR
// board between instruction fetches and diagnostic EBUS functions 06X / 13X.
module ir_load_sequencer
    import ir_ctl_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES    = 1,
    parameter int unsigned DIAG_READ_CYCLES = 2,
    parameter int unsigned CACHE_TIMEOUT    = 15
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       irReq,
    input  logic       irSrcAD,
    input  logic       cacheValid,
    input  logic       diagStrobe,
    input  logic [6:0] diagFunc,
    output logic       loadIR,
    output logic       mbXfer,
    output logic       loadDRAM,
    output logic       diagLoadFunc06X,
    output logic       diagReadFunc13X,
    output logic       dispValid,
    output logic       busy,
    output logic       fetchTimeout
);

    localparam logic [7:0] SETTLE_LOAD  = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0] READ_LOAD    = 8'(DIAG_READ_CYCLES - 1);
    localparam logic [7:0] TIMEOUT_LOAD = 8'(CACHE_TIMEOUT - 1);

    ir_state_t  state, state_nxt;
    logic       src_ad, src_nxt;
    logic       cnt_load, cnt_dec, cnt_zero;
    logic [7:0] cnt_val;
    logic       timeout_set, timeout_clr;
    logic       diag_ld, diag_rd;

    ir_seq_counter u_cnt (
        .clk      (clk),
        .resetN   (resetN),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    assign diag_ld = diagStrobe && diag_in_group(diagFunc, DIAG_LOAD_06X_BASE);
    assign diag_rd = diagStrobe && diag_in_group(diagFunc, DIAG_READ_13X_BASE);

    always_comb begin
        state_nxt   = state;
        src_nxt     = src_ad;
        cnt_load    = 1'b0;
        cnt_val     = '0;
        cnt_dec     = 1'b0;
        timeout_set = 1'b0;
        timeout_clr = 1'b0;
        case (state)
            ST_IDLE, ST_VALID: begin
                // Diag wins a collision; an unrecognised code does not block irReq.
                if (diag_ld) begin
                    state_nxt = ST_DIAG_LOAD;
                end else if (diag_rd) begin
                    state_nxt = ST_DIAG_READ;
                    cnt_load  = 1'b1;
                    cnt_val   = READ_LOAD;
                end else if (irReq) begin
                    src_nxt     = irSrcAD;
                    timeout_clr = 1'b1;
                    if (irSrcAD || cacheValid) begin
                        state_nxt = ST_LOAD_IR;
                    end else begin
                        state_nxt = ST_WAIT_CACHE;
                        cnt_load  = 1'b1;
                        cnt_val   = TIMEOUT_LOAD;
                    end
                end
            end
            ST_WAIT_CACHE: begin
                if (cacheValid) begin
                    state_nxt = ST_LOAD_IR;
                end else if (cnt_zero) begin
                    state_nxt   = ST_IDLE;
                    timeout_set = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_LOAD_IR: begin
                state_nxt = ST_SETTLE;
                cnt_load  = 1'b1;
                cnt_val   = SETTLE_LOAD;
            end
            ST_SETTLE: begin
                if (cnt_zero) state_nxt = ST_LOAD_DRAM;
                else          cnt_dec   = 1'b1;
            end
            ST_LOAD_DRAM: state_nxt = ST_VALID;
            ST_DIAG_LOAD: state_nxt = ST_IDLE;
            ST_DIAG_READ: begin
                if (cnt_zero) state_nxt = ST_IDLE;
                else          cnt_dec   = 1'b1;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are registered copies of the next-state decode, so they line up
    // with the state they describe and a reset clears them immediately.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state           <= ST_IDLE;
            src_ad          <= 1'b0;
            loadIR          <= 1'b0;
            mbXfer          <= 1'b0;
            loadDRAM        <= 1'b0;
            diagLoadFunc06X <= 1'b0;
            diagReadFunc13X <= 1'b0;
            dispValid       <= 1'b0;
            busy            <= 1'b0;
            fetchTimeout    <= 1'b0;
        end else begin
            state           <= state_nxt;
            src_ad          <= src_nxt;
            loadIR          <= (state_nxt == ST_LOAD_IR);
            mbXfer          <= (state_nxt == ST_LOAD_IR) && src_nxt;
            loadDRAM        <= (state_nxt == ST_LOAD_DRAM);
            diagLoadFunc06X <= (state_nxt == ST_DIAG_LOAD);
            diagReadFunc13X <= (state_nxt == ST_DIAG_READ);
            dispValid       <= (state_nxt == ST_VALID);
            busy            <= !((state_nxt == ST_IDLE) || (state_nxt == ST_VALID));
            if (timeout_set)      fetchTimeout <= 1'b1;
            else if (timeout_clr) fetchTimeout <= 1'b0;
        end
    end

    a_pulse_exclusive: assert property (@(posedge clk) disable iff (!resetN)
        $onehot0({loadIR, loadDRAM, diagLoadFunc06X, diagReadFunc13X}));

endmodule
